// File: rtl/dest_select_pipe.sv
// dest_select_pipe
// Chooses the destination register of the decode-stage instruction and carries
// it through a STAGES-deep in-flight pipeline up to write-back. Each decode
// source operand is compared against the in-flight destinations. The youngest
// matching stage is reported so that decode can stall or forward.
//
// Handshake: at a rising edge with adv=1 and flush=0, the decode instruction
// (in_valid, A/B/sel) is captured into stage 0, and every stage moves down by
// one. At an edge with adv=0, nothing moves and the decode instruction is not
// captured; upstream must hold it. flush=1 invalidates every stage and takes
// priority over adv. The decode instruction presented on a flush edge is
// dropped.
module dest_select_pipe #(
    parameter int ADDR_W   = 6,
    parameter int STAGES   = 3,
    parameter int LINK_REG = 31,
    parameter int ZERO_REG = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              adv,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [ADDR_W-1:0] A,
    input  logic [ADDR_W-1:0] B,
    input  logic [1:0]        sel,
    input  logic [ADDR_W-1:0] src1,
    input  logic [ADDR_W-1:0] src2,
    input  logic              src1_used,
    input  logic              src2_used,
    output logic [ADDR_W-1:0] dest,
    output logic              hazard,
    output logic [STAGES-1:0] hit1,
    output logic [STAGES-1:0] hit2,
    output logic [ADDR_W-1:0] wb_dest,
    output logic              wb_valid
);

    // Out-of-range register constants or depths are rejected at elaboration.
    generate
        if (LINK_REG < 0 || LINK_REG >= (1 << ADDR_W)) begin : g_bad_link
            $error("LINK_REG does not fit in ADDR_W bits");
        end
        if (ZERO_REG < 0 || ZERO_REG >= (1 << ADDR_W)) begin : g_bad_zero
            $error("ZERO_REG does not fit in ADDR_W bits");
        end
        if (STAGES < 2 || STAGES > 8) begin : g_bad_stages
            $error("STAGES must be in 2..8");
        end
    endgenerate

    localparam logic [ADDR_W-1:0] LINK_A = ADDR_W'(LINK_REG);
    localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(ZERO_REG);

    // Stage 0 is the youngest entry (EX). Stage STAGES-1 is write-back.
    logic [ADDR_W-1:0] r_dest [STAGES];
    logic [STAGES-1:0] r_valid;

    logic [ADDR_W-1:0] w_dest;
    logic              w_wr;
    logic [STAGES-1:0] w_match1;
    logic [STAGES-1:0] w_match2;

    // Destination mux and write qualification. A write to the zero register becomes a bubble.
    always_comb begin
        w_dest = '0;
        case (sel)
            2'b00:   w_dest = A;
            2'b01:   w_dest = B;
            2'b10:   w_dest = LINK_A;
            default: w_dest = '0;
        endcase
        w_wr = in_valid && (sel != 2'b11) && (w_dest != ZERO_A);
    end

    // In-flight stage register: flush clears valids (dests hold), adv shifts, otherwise freeze.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= '0;
            for (int i = 0; i < STAGES; i++) begin
                r_dest[i] <= '0;
            end
        end else if (flush) begin
            r_valid <= '0;
        end else if (adv) begin
            r_dest[0]  <= w_dest;
            r_valid[0] <= w_wr;
            for (int i = 1; i < STAGES; i++) begin
                r_dest[i]  <= r_dest[i-1];
                r_valid[i] <= r_valid[i-1];
            end
        end
    end

    // Raw per-stage RAW matches for both source operands.
    always_comb begin
        w_match1 = '0;
        w_match2 = '0;
        for (int i = 0; i < STAGES; i++) begin
            w_match1[i] = src1_used && (src1 != ZERO_A) && r_valid[i] && (r_dest[i] == src1);
            w_match2[i] = src2_used && (src2 != ZERO_A) && r_valid[i] && (r_dest[i] == src2);
        end
    end

    // Isolate the youngest match. Scanning from oldest to youngest lets the lowest index win.
    always_comb begin
        hit1 = '0;
        hit2 = '0;
        for (int i = STAGES - 1; i >= 0; i--) begin
            if (w_match1[i]) begin
                hit1 = STAGES'(1) << i;
            end
            if (w_match2[i]) begin
                hit2 = STAGES'(1) << i;
            end
        end
    end

    assign dest     = w_dest;
    assign hazard   = (|w_match1) | (|w_match2);
    assign wb_dest  = r_dest[STAGES-1];
    assign wb_valid = r_valid[STAGES-1];

endmodule

// File: doc/dest_select_pipe.md
Name: dest_select_pipe

Overview:
- Parametrised successor to the processor's destination-register selector.
- Adds a third selection mode (link register) and a "no write" mode.
- Tracks each selected destination through a STAGES-deep in-flight pipeline up to write-back.
- Flags read-after-write hazards against two source operands, reporting the youngest matching stage so decode can stall or forward.

Parameters:
ADDR_W, 6, register index width
STAGES, 3, number of in-flight stages tracked (EX..WB); legal range 2..8
LINK_REG, 31, register index written by link-mode instructions
ZERO_REG, 0, hardwired-zero register; never marked as a pending write and never flagged as a hazard

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous reset, active-high
adv  input  1  pipeline advance enable; 0 freezes all stages
flush  input  1  clear all in-flight valid bits
in_valid  input  1  decode-stage instruction present
A  input  ADDR_W  first destination candidate (rd field)
B  input  ADDR_W  second destination candidate (rt field)
sel  input  2  00=A, 01=B, 10=LINK_REG, 11=no write
src1  input  ADDR_W  first source register of decode instruction
src2  input  ADDR_W  second source register
src1_used  input  1  src1 is actually read
src2_used  input  1  src2 is actually read
dest  output  ADDR_W  combinational selected destination (0 when sel=11)
hazard  output  1  combinational RAW hazard against any valid in-flight stage
hit1  output  STAGES  one-hot, youngest stage matching src1 (bit 0 = youngest)
hit2  output  STAGES  one-hot, youngest stage matching src2
wb_dest  output  ADDR_W  destination in last stage
wb_valid  output  1  last stage holds a real pending write

Behaviour:
- Reset (async, rst=1):
  - all stage dest fields = 0, all stage valid bits = 0.
  - Hence wb_dest=0, wb_valid=0, hit1=hit2=0, hazard=0 while rst is held, regardless of src inputs.
- Selection (combinational):
  - dest = A / B / LINK_REG / 0 according to sel.
  - wr = in_valid & (sel!=11) & (dest!=ZERO_REG).
- Stage register, per rising edge, priority order:
  - flush=1: every valid bit <= 0. Dest fields hold. flush wins over adv.
  - else adv=1: stage0 <= {wr, dest}; stage[i] <= stage[i-1] for i=1..STAGES-1. The previous last-stage entry is retired.
  - else: all stages hold. A decode instruction presented with adv=0 is not captured; upstream holds it.
- Latency: an entry captured on edge n appears at the last stage (wb_dest/wb_valid) after STAGES-1 further adv edges. Frozen cycles extend this 1:1.
- Hazard detection (combinational from registered stages and current src inputs):
  - raw match: match1[i] = src1_used & (src1!=ZERO_REG) & valid[i] & (stage_dest[i]==src1). match2 likewise for src2.
  - hit1 = lowest-index set bit of match1, isolated to one-hot, or 0 if none. hit2 likewise.
  - hazard = |match1 | |match2.
  - The decode instruction itself is not compared against its own dest.
- Boundary conditions:
  - Multiple stages writing the same register: only the youngest is reported.
  - src1==src2: hit1 and hit2 are identical.
  - sel=11 or dest==ZERO_REG: the bubble advances with valid=0.
  - flush and adv both high: all entries invalid after the edge; the decode entry is discarded.
  - rst asserted mid-stream: outputs clear immediately, without waiting for a clock edge.
- Widths: all comparisons are full ADDR_W equality; no truncation. LINK_REG and ZERO_REG must fit in ADDR_W; elaboration fails otherwise.
- No internal state other than STAGES x (ADDR_W+1) flops.

Test Plan:
- Reset: rst=1 with src1=5, src1_used=1 -> hazard=0, wb_valid=0, wb_dest=0. Release rst, then A=5, sel=00, in_valid=1, adv=1 for 1 edge -> hit1=001, hazard=1.
- Modes: sel=00/01/10/11 with A=7, B=9 -> dest=7, 9, 31, 0. After 3 adv edges, wb sequence is (7,1), (9,1), (31,1), (0,0).
- Zero register and stall: A=0, sel=00, in_valid=1, adv=1 -> stage0 valid=0, no hazard for src1=0. Then hold adv=0 for 4 cycles with an entry in stage1 -> hit1 stays constant and wb_valid unchanged.
- Youngest priority: write r12 on two consecutive adv edges -> src2=12, src2_used=1 gives hit2=001 (not 011). One more adv with sel=11 -> hit2=010.
- Flush: fill all 3 stages with r3, r4, r5; assert flush=1 with adv=1 and A=6 -> next cycle all valid=0, hazard=0 for src1=6, wb_valid=0.
- Async reset mid-operation: stages full with valid entries; raise rst between edges -> wb_valid and hazard drop within the same cycle, with no clock edge needed.
